// File: rtl/renkon_output_drain_pkg.sv
// Shared constants and FSM encoding for the Renkon output drain.
package renkon_output_drain_pkg;

  localparam int unsigned DWIDTH  = 16;  // data word width
  localparam int unsigned CORE    = 8;   // core count
  localparam int unsigned CORELOG = 3;   // log2(CORE)
  localparam int unsigned OADDR   = 12;  // core output buffer address width
  localparam int unsigned MADDR   = 16;  // external memory address width

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/renkon_output_drain_if.sv
// Control, output-buffer read and external memory write signals of the drain.
// master: the drain engine; slave: the surrounding system.
interface renkon_output_drain_if;
  import renkon_output_drain_pkg::*;

  logic                      start;
  logic [CORELOG:0]          n_core;
  logic [OADDR:0]            n_word;
  logic [MADDR-1:0]          out_base;
  logic [CORELOG:0]          output_re;
  logic [OADDR-1:0]          output_addr;
  logic signed [DWIDTH-1:0]  read_output;
  logic                      mem_we;
  logic [MADDR-1:0]          mem_addr;
  logic signed [DWIDTH-1:0]  mem_wdata;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, n_core, n_word, out_base, read_output,
    output output_re, output_addr, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    output start, n_core, n_word, out_base, read_output,
    input  output_re, output_addr, mem_we, mem_addr, mem_wdata, busy, done
  );

endinterface

// File: rtl/renkon_output_pipe.sv
// Two-stage delay line carrying a read-valid tag and its destination write address,
// matching the buffer-read plus mux-register latency of the read data.
module renkon_output_pipe #(
  parameter int unsigned AddrW = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [AddrW-1:0] addr_i,
  output logic             valid_o,
  output logic [AddrW-1:0] addr_o,
  output logic             empty_o
);

  logic [1:0]       valid_q;
  logic [AddrW-1:0] addr0_q;
  logic [AddrW-1:0] addr1_q;

  // Shift tag and address together; reset drops any in-flight reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
    end else begin
      valid_q <= {valid_q[0], valid_i};
      addr0_q <= addr_i;
      addr1_q <= addr0_q;
    end
  end

  assign valid_o = valid_q[1];
  assign addr_o  = addr1_q;
  assign empty_o = (valid_q == 2'b00);

endmodule

// File: rtl/renkon_output_drain.sv
// Drains core output buffers to external memory in core-major order.
// Optional build macro RENKON_OUT_RELU_EN clamps negative write data to zero.
module renkon_output_drain
  import renkon_output_drain_pkg::*;
(
  input logic                   clk,
  input logic                   xrst,
  renkon_output_drain_if.master drain_io
);

  localparam logic [CORELOG:0] CoreMax = (CORELOG + 1)'(CORE);
  localparam logic [CORELOG:0] CoreOne = 1;
  localparam logic [OADDR:0]   WordOne = 1;
  localparam logic [MADDR-1:0] IdxOne  = 1;

  drain_state_e             state_q;
  logic [CORELOG:0]         n_core_q;
  logic [OADDR:0]           n_word_q;
  logic [MADDR-1:0]         base_q;
  logic [CORELOG:0]         core_q;
  logic [OADDR:0]           word_q;
  logic [MADDR-1:0]         idx_q;
  logic [CORELOG:0]         output_re_q;
  logic [OADDR-1:0]         output_addr_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     mem_we_q;
  logic [MADDR-1:0]         mem_addr_q;
  logic signed [DWIDTH-1:0] mem_wdata_q;

  logic [CORELOG:0]         n_core_eff;
  logic [CORELOG:0]         core_nxt;
  logic [OADDR:0]           word_nxt;
  logic                     issuing;
  logic                     last_word;
  logic                     last_core;
  logic                     pipe_valid;
  logic [MADDR-1:0]         pipe_addr;
  logic                     pipe_empty;
  logic signed [DWIDTH-1:0] wdata_d;

  // Clamp the core count and derive the read-walk increments.
  always_comb begin
    n_core_eff = drain_io.n_core;
    if (drain_io.n_core == '0 || drain_io.n_core > CoreMax) begin
      n_core_eff = CoreMax;
    end
    core_nxt  = core_q + CoreOne;
    word_nxt  = word_q + WordOne;
    // A nonzero core select marks a read being issued this cycle.
    issuing   = (output_re_q != '0);
    last_word = (word_nxt == n_word_q);
    last_core = (core_nxt == n_core_q);
  end

  // Drain FSM: latches the job, walks cores/words and drives the read port.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q       <= StIdle;
      n_core_q      <= '0;
      n_word_q      <= '0;
      base_q        <= '0;
      core_q        <= '0;
      word_q        <= '0;
      idx_q         <= '0;
      output_re_q   <= '0;
      output_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (drain_io.start) begin
            state_q  <= StIssue;
            busy_q   <= 1'b1;
            n_core_q <= n_core_eff;
            n_word_q <= drain_io.n_word;
            base_q   <= drain_io.out_base;
            core_q   <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            if (drain_io.n_word != '0) begin
              output_re_q   <= CoreOne;
              output_addr_q <= '0;
            end else begin
              output_re_q <= '0;
            end
          end
        end
        StIssue: begin
          if (!issuing) begin
            state_q <= StFlush;
          end else begin
            idx_q <= idx_q + IdxOne;
            if (last_word) begin
              word_q <= '0;
              if (last_core) begin
                state_q     <= StFlush;
                output_re_q <= '0;
              end else begin
                core_q        <= core_nxt;
                output_re_q   <= core_nxt + CoreOne;
                output_addr_q <= '0;
              end
            end else begin
              word_q        <= word_nxt;
              output_addr_q <= word_nxt[OADDR-1:0];
            end
          end
        end
        StFlush: begin
          if (pipe_empty) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  renkon_output_pipe #(
    .AddrW (MADDR)
  ) u_pipe (
    .clk_i   (clk),
    .rst_i   (xrst),
    .valid_i (issuing),
    .addr_i  (base_q + idx_q),
    .valid_o (pipe_valid),
    .addr_o  (pipe_addr),
    .empty_o (pipe_empty)
  );

  // Write-data shaping; timing is the same with or without the clamp.
  always_comb begin
`ifdef RENKON_OUT_RELU_EN
    wdata_d = drain_io.read_output[DWIDTH-1] ? '0 : drain_io.read_output;
`else
    wdata_d = drain_io.read_output;
`endif
  end

  // Memory write register: one strobe per tagged read, address and data hold otherwise.
  always_ff @(posedge clk) begin
    if (xrst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= pipe_valid;
      if (pipe_valid) begin
        mem_addr_q  <= pipe_addr;
        mem_wdata_q <= wdata_d;
      end
    end
  end

  assign drain_io.output_re   = output_re_q;
  assign drain_io.output_addr = output_addr_q;
  assign drain_io.mem_we      = mem_we_q;
  assign drain_io.mem_addr    = mem_addr_q;
  assign drain_io.mem_wdata   = mem_wdata_q;
  assign drain_io.busy        = busy_q;
  assign drain_io.done        = done_q;

endmodule

// File: tb/tb_renkon_output_drain.sv
// Bench for renkon_output_drain: table of directed drains, reset/ignore-start
// sequences and randomized drains against a list-based reference model.
module tb_renkon_output_drain;
  import renkon_output_drain_pkg::*;

  logic clk = 1'b0;
  logic xrst = 1'b1;
  always #5 clk = ~clk;

  renkon_output_drain_if bus ();

  renkon_output_drain dut (
    .clk      (clk),
    .xrst     (xrst),
    .drain_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core output buffers and the registered output mux around them.
  logic signed [15:0] bufm [8][4096];
  logic signed [15:0] stage1;
  always @(posedge clk) begin
    stage1 <= (bus.output_re == '0) ? 16'sd0 : bufm[3'(bus.output_re - 4'd1)][bus.output_addr];
    bus.read_output <= stage1;
  end

  // Write/done monitor, sampled on the falling edge.
  logic [15:0]        got_addr [$];
  logic signed [15:0] got_data [$];
  int   last_we_cyc, done_cyc, done_cnt;
  logic done_busy;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr.push_back(bus.mem_addr);
      got_data.push_back(bus.mem_wdata);
      last_we_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_busy = bus.busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [15:0] model_data(input logic signed [15:0] v);
`ifdef RENKON_OUT_RELU_EN
    return (v < 0) ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill(input int mode);
    for (int c = 0; c < 8; c++) begin
      for (int w = 0; w < 4096; w++) begin
        case (mode)
          0:       bufm[c][w] = 16'(c * 16 + w);
          1:       bufm[c][w] = 16'(c * 4096 + w);
          2:       bufm[c][w] = 16'($urandom);
          default: bufm[c][w] = -16'sd5;
        endcase
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " output_re"},   32'(bus.output_re),   0);
    chk({tag, " output_addr"}, 32'(bus.output_addr), 0);
    chk({tag, " mem_we"},      32'(bus.mem_we),      0);
    chk({tag, " mem_addr"},    32'(bus.mem_addr),    0);
    chk({tag, " mem_wdata"},   {16'd0, bus.mem_wdata}, 0);
    chk({tag, " done"},        32'(bus.done),        0);
    chk({tag, " busy"},        32'(bus.busy),        0);
  endtask

  // One drain: reference list from the rules, then compare the observed writes.
  task automatic run_drain(input int nc, input int nw, input int base, input int glitch,
                           input int exp_n, input string tag);
    logic [15:0]        exp_addr [$];
    logic signed [15:0] exp_data [$];
    int nce, k, s, budget;
    nce = (nc == 0 || nc > 8) ? 8 : nc;
    k = 0;
    for (int c = 0; c < nce; c++) begin
      for (int w = 0; w < nw; w++) begin
        exp_addr.push_back(16'(base + k));
        exp_data.push_back(model_data(bufm[c][w]));
        k++;
      end
    end
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    bus.n_core   = 4'(nc);
    bus.n_word   = 13'(nw);
    bus.out_base = 16'(base);
    bus.start    = 1'b1;
    s = cyc;
    step();
    bus.start = 1'b0;
    chk({tag, " busy after start"}, 32'(bus.busy), 1);
    budget = nce * nw + 40;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      if (k == glitch) begin
        bus.n_word   = 13'(nw + 7);
        bus.out_base = 16'(base + 16'h55);
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
      k++;
    end
    bus.start = 1'b0;
    chk({tag, " done seen"}, 32'(done_cnt > 0), 1);
    repeat (3) step();
    chk({tag, " done pulses"}, 32'(done_cnt), 1);
    chk({tag, " busy at done"}, 32'(done_busy), 0);
    chk({tag, " write count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    if (exp_n >= 0) chk({tag, " table count"}, 32'(got_addr.size()), 32'(exp_n));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("%s data[%0d]", tag, i), {16'd0, got_data[i]}, {16'd0, exp_data[i]});
    end
    if (exp_addr.size() > 0) chk({tag, " done after last write"}, 32'(done_cyc - last_we_cyc), 1);
    else                     chk({tag, " done after start"},      32'(done_cyc - s), 3);
  endtask

  typedef struct {
    int    nc;
    int    nw;
    int    base;
    int    mode;
    int    glitch;
    int    exp_n;
    string tag;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, 3,    16'h0100, 0, -1, 6,    "basic_2x3"};
    vecs[1] = '{1, 0,    16'h0200, 1, -1, 0,    "zero_words"};
    vecs[2] = '{1, 4,    16'hFFFE, 1, -1, 4,    "addr_wrap"};
    vecs[3] = '{0, 2,    16'h0010, 1, -1, 16,   "clamp_zero"};
    vecs[4] = '{12, 1,   16'h0020, 1, -1, 8,    "clamp_big"};
    vecs[5] = '{2, 3,    16'h0300, 1, 2,  6,    "start_busy"};
    vecs[6] = '{1, 3,    16'h0040, 3, -1, 3,    "neg_data"};
    vecs[7] = '{8, 0,    16'h0000, 1, -1, 0,    "zero_words_8"};
    vecs[8] = '{1, 4096, 16'h1000, 1, -1, 4096, "full_words"};

    bus.start    = 1'b0;
    bus.n_core   = '0;
    bus.n_word   = '0;
    bus.out_base = '0;
    xrst = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    xrst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      fill(vecs[i].mode);
      run_drain(vecs[i].nc, vecs[i].nw, vecs[i].base, vecs[i].glitch, vecs[i].exp_n,
                vecs[i].tag);
      step();
    end

    // Reset five cycles into an 8x16 drain, then start on the first free cycle.
    fill(1);
    bus.n_core   = 4'd8;
    bus.n_word   = 13'd16;
    bus.out_base = 16'h0500;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    xrst = 1'b1;
    step();
    xrst = 1'b0;
    chk_zero("mid_reset");
    run_drain(8, 16, 16'h0600, -1, 128, "after_reset");

    for (int i = 0; i < 8; i++) begin
      fill(2);
      repeat ($urandom_range(0, 3)) step();
      run_drain(int'($urandom_range(0, 15)), int'($urandom_range(0, 24)),
                int'($urandom_range(0, 65535)), -1, -1, $sformatf("random%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
